// File: rtl/int_ctrl_pkg.sv
// Shared types and constants for the interrupt controller.
// Latency: none (declarations only).
// Backpressure: not applicable.
package int_ctrl_pkg;

    // Controller phases: waiting, requesting the control unit, ISR running.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    // Upper bound on the number of sources; sizes every source index.
    localparam int MAX_SRC = 8;
    localparam int IDX_W   = $clog2(MAX_SRC);

    // Vector of source 0 in the default memory map.
    localparam logic [9:0] VEC_BASE_DEF = 10'h3F0;

endpackage

// File: rtl/int_prio_enc.sv
// Fixed-priority encoder: finds the lowest set bit of vec (bit 0 wins).
// Latency: purely combinational.
// Backpressure: none; the output always follows the input.
module int_prio_enc
    import int_ctrl_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]     vec,
    output logic             vld,
    output logic [IDX_W-1:0] idx
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        vld = 1'b0;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                vld = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: rising-edge capture, mask, fixed priority, single-level ISR tracking.
// Latency: int_req rises two cycles after an irq edge (edge capture, then arbitration).
// Backpressure: int_req and int_vector hold steady until int_ack or di. Macro INTC_NESTING_EN enables preemption.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int                N_SRC    = 4,
    parameter int                ADDR_W   = 10,
    parameter logic [ADDR_W-1:0] VEC_BASE = ADDR_W'(VEC_BASE_DEF)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_SRC-1:0]  irq,
    input  logic              mask_we,
    input  logic [N_SRC-1:0]  mask_din,
    input  logic              ei,
    input  logic              di,
    input  logic              reti,
    input  logic              int_ack,
    output logic              int_req,
    output logic [ADDR_W-1:0] int_vector,
    output logic              in_service,
    output logic [N_SRC-1:0]  pending,
    output logic              ie
);

    state_t             state;
    state_t             state_nxt;
    logic [N_SRC-1:0]   irq_q;
    logic [N_SRC-1:0]   rise;
    logic [N_SRC-1:0]   pend_q;
    logic [N_SRC-1:0]   mask_q;
    logic [N_SRC-1:0]   eligible;
    logic [N_SRC-1:0]   clr;
    logic               ie_q;
    logic               ie_nxt;
    logic [IDX_W-1:0]   id_q;
    logic [IDX_W-1:0]   id_nxt;
    logic               win_vld;
    logic [IDX_W-1:0]   win_idx;

    assign rise     = irq & ~irq_q;
    assign eligible = pend_q & mask_q;
    assign pending  = pend_q;
    assign ie       = ie_q;

    int_prio_enc #(.N(N_SRC)) u_win (
        .vec (eligible),
        .vld (win_vld),
        .idx (win_idx)
    );

`ifdef INTC_NESTING_EN
    // One bit per source currently in service; depth never exceeds N_SRC,
    // which the CPU's hardware stack has to accommodate.
    logic [N_SRC-1:0]   isr_q;
    logic [N_SRC-1:0]   isr_nxt;
    logic [N_SRC-1:0]   isr_low;
    logic               isr_vld;
    logic [IDX_W-1:0]   isr_idx;

    int_prio_enc #(.N(N_SRC)) u_isr (
        .vec (isr_q),
        .vld (isr_vld),
        .idx (isr_idx)
    );

    assign isr_low    = isr_vld ? (N_SRC'(1) << isr_idx) : '0;
    assign in_service = |isr_q;
`else
    assign in_service = (state == SERVICE);
`endif

    // Next-state, request outputs, pending-clear and ie update.
    always_comb begin
        state_nxt  = state;
        id_nxt     = id_q;
        clr        = '0;
        int_req    = 1'b0;
        int_vector = VEC_BASE;
        ie_nxt     = ie_q;
        if (ei) ie_nxt = 1'b1;
        if (di) ie_nxt = 1'b0;
`ifdef INTC_NESTING_EN
        isr_nxt = isr_q;
        if (reti && isr_vld) begin
            isr_nxt = isr_q & ~isr_low;
            // Only the return that empties the in-service set re-enables.
            if ((isr_q & ~isr_low) == '0) ie_nxt = 1'b1;
        end
`endif
        case (state)
            IDLE: begin
                if (ie_q && win_vld) begin
                    id_nxt    = win_idx;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                int_req    = 1'b1;
                int_vector = VEC_BASE + ADDR_W'(id_q);
                if (int_ack) begin
                    clr       = N_SRC'(1) << id_q;
                    ie_nxt    = 1'b0;
                    state_nxt = SERVICE;
`ifdef INTC_NESTING_EN
                    isr_nxt   = isr_nxt | clr;
`endif
                end else if (di) begin
`ifdef INTC_NESTING_EN
                    state_nxt = (isr_nxt == '0) ? IDLE : SERVICE;
`else
                    state_nxt = IDLE;
`endif
                end
            end
            SERVICE: begin
`ifdef INTC_NESTING_EN
                if (reti && isr_vld) begin
                    if (isr_nxt == '0) state_nxt = IDLE;
                end else if (ie_q && win_vld && (win_idx < isr_idx)) begin
                    id_nxt    = win_idx;
                    state_nxt = REQ;
                end
`else
                if (reti) begin
                    ie_nxt    = 1'b1;
                    state_nxt = IDLE;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, capture and configuration registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            irq_q  <= '0;
            pend_q <= '0;
            mask_q <= '0;
            ie_q   <= 1'b0;
            id_q   <= '0;
        end else begin
            state  <= state_nxt;
            irq_q  <= irq;
            // A rise on the ack cycle survives the clear of the same bit.
            pend_q <= (pend_q & ~clr) | rise;
            if (mask_we) mask_q <= mask_din;
            ie_q   <= ie_nxt;
            id_q   <= id_nxt;
        end
    end

`ifdef INTC_NESTING_EN
    // In-service set for nested interrupts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) isr_q <= '0;
        else       isr_q <= isr_nxt;
    end
`endif

endmodule

// File: tb/tb_int_ctrl.sv
module tb_int_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] irq;
    logic       mask_we;
    logic [3:0] mask_din;
    logic       ei;
    logic       di;
    logic       reti;
    logic       int_ack;
    logic       int_req;
    logic [9:0] int_vector;
    logic       in_service;
    logic [3:0] pending;
    logic       ie;

    int n_cmp = 0;
    int n_err = 0;

    int_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .irq        (irq),
        .mask_we    (mask_we),
        .mask_din   (mask_din),
        .ei         (ei),
        .di         (di),
        .reti       (reti),
        .int_ack    (int_ack),
        .int_req    (int_req),
        .int_vector (int_vector),
        .in_service (in_service),
        .pending    (pending),
        .ie         (ie)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        irq = 4'b0; mask_we = 0; mask_din = 4'b0; ei = 0; di = 0; reti = 0; int_ack = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    // ---------------- reference model (single-level behaviour) ----------------
    // Phase: 0 = waiting, 1 = requesting, 2 = ISR running.
    int         m_phase;
    int         m_src;
    logic [3:0] m_pend, m_mask, m_prev;
    logic       m_ie;

    function automatic int lowest_set(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_src = 0; m_pend = 0; m_mask = 0; m_prev = 0; m_ie = 0;
    endtask

    // Applies one clock of the rules to the values sampled before the edge.
    task automatic model_clock();
        logic [3:0] served;
        logic       ie_new;
        int         phase_new, w;
        served = 4'b0;
        ie_new = m_ie;
        if (ei) ie_new = 1'b1;
        if (di) ie_new = 1'b0;
        phase_new = m_phase;
        w = lowest_set(m_pend & m_mask);
        if (m_phase == 0 && m_ie && w >= 0) begin
            m_src = w; phase_new = 1;
        end else if (m_phase == 1 && int_ack) begin
            served[m_src] = 1'b1; ie_new = 1'b0; phase_new = 2;
        end else if (m_phase == 1 && di) begin
            phase_new = 0;
        end else if (m_phase == 2 && reti) begin
            ie_new = 1'b1; phase_new = 0;
        end
        m_pend  = (m_pend & ~served) | (irq & ~m_prev);
        m_prev  = irq;
        if (mask_we) m_mask = mask_din;
        m_ie    = ie_new;
        m_phase = phase_new;
    endtask

    // ---------------- directed tests ----------------
    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        #3;
        n_cmp++; if (int_req !== 1'b0) begin n_err++; $display("FAIL reset_req got %b want 0", int_req); end
        n_cmp++; if (int_vector !== 10'h3F0) begin n_err++; $display("FAIL reset_vec got %h want 3f0", int_vector); end
        n_cmp++; if (in_service !== 1'b0) begin n_err++; $display("FAIL reset_insvc got %b want 0", in_service); end
        n_cmp++; if (pending !== 4'b0) begin n_err++; $display("FAIL reset_pend got %b want 0000", pending); end
        n_cmp++; if (ie !== 1'b0) begin n_err++; $display("FAIL reset_ie got %b want 0", ie); end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        mask_we = 1; mask_din = 4'b1111; ei = 1;
        tick();
        idle_inputs();
        irq = 4'b0100;
        tick();
        n_cmp++; if (int_req !== 1'b0) begin n_err++; $display("FAIL basic_early got %b want 0", int_req); end
        tick();
        irq = 4'b0;
        n_cmp++; if (int_req !== 1'b1) begin n_err++; $display("FAIL basic_req got %b want 1", int_req); end
        n_cmp++; if (int_vector !== 10'h3F2) begin n_err++; $display("FAIL basic_vec got %h want 3f2", int_vector); end
        int_ack = 1;
        tick();
        int_ack = 0;
        n_cmp++; if (pending !== 4'b0000) begin n_err++; $display("FAIL basic_pend got %b want 0000", pending); end
        n_cmp++; if (ie !== 1'b0) begin n_err++; $display("FAIL basic_ie_ack got %b want 0", ie); end
        n_cmp++; if (in_service !== 1'b1) begin n_err++; $display("FAIL basic_insvc got %b want 1", in_service); end
        n_cmp++; if (int_req !== 1'b0) begin n_err++; $display("FAIL basic_req_off got %b want 0", int_req); end
        reti = 1;
        tick();
        reti = 0;
        n_cmp++; if (ie !== 1'b1) begin n_err++; $display("FAIL basic_ie_reti got %b want 1", ie); end
        n_cmp++; if (in_service !== 1'b0) begin n_err++; $display("FAIL basic_idle got %b want 0", in_service); end
    endtask

    task automatic test_priority();
        irq = 4'b1010;
        tick();
        irq = 4'b0;
        tick();
        n_cmp++; if (int_vector !== 10'h3F1 || int_req !== 1'b1) begin n_err++; $display("FAIL prio_first got req=%b vec=%h want req=1 vec=3f1", int_req, int_vector); end
        int_ack = 1;
        tick();
        int_ack = 0;
        n_cmp++; if (pending !== 4'b1000) begin n_err++; $display("FAIL prio_pend got %b want 1000", pending); end
        reti = 1;
        tick();
        reti = 0;
        tick();
        n_cmp++; if (int_vector !== 10'h3F3 || int_req !== 1'b1) begin n_err++; $display("FAIL prio_second got req=%b vec=%h want req=1 vec=3f3", int_req, int_vector); end
        int_ack = 1;
        tick();
        int_ack = 0; reti = 1;
        tick();
        reti = 0;
    endtask

    task automatic test_mask();
        mask_we = 1; mask_din = 4'b1011;
        tick();
        mask_we = 0; irq = 4'b0100;
        tick();
        irq = 4'b0;
        tick();
        tick();
        n_cmp++; if (int_req !== 1'b0) begin n_err++; $display("FAIL mask_blocked got %b want 0", int_req); end
        n_cmp++; if (pending !== 4'b0100) begin n_err++; $display("FAIL mask_pend got %b want 0100", pending); end
        mask_we = 1; mask_din = 4'b1111;
        tick();
        mask_we = 0;
        tick();
        n_cmp++; if (int_req !== 1'b1 || int_vector !== 10'h3F2) begin n_err++; $display("FAIL mask_unmask got req=%b vec=%h want req=1 vec=3f2", int_req, int_vector); end
        int_ack = 1;
        tick();
        int_ack = 0; reti = 1;
        tick();
        reti = 0;
    endtask

    task automatic test_di_drop();
        irq = 4'b0010;
        tick();
        irq = 4'b0;
        tick();
        n_cmp++; if (int_req !== 1'b1) begin n_err++; $display("FAIL di_req got %b want 1", int_req); end
        di = 1;
        tick();
        di = 0;
        n_cmp++; if (int_req !== 1'b0) begin n_err++; $display("FAIL di_drop got %b want 0", int_req); end
        n_cmp++; if (pending !== 4'b0010) begin n_err++; $display("FAIL di_pend got %b want 0010", pending); end
        n_cmp++; if (ie !== 1'b0 || in_service !== 1'b0) begin n_err++; $display("FAIL di_state got ie=%b insvc=%b want 0 0", ie, in_service); end
        ei = 1;
        tick();
        ei = 0;
        tick();
        n_cmp++; if (int_req !== 1'b1 || int_vector !== 10'h3F1) begin n_err++; $display("FAIL di_reraise got req=%b vec=%h want req=1 vec=3f1", int_req, int_vector); end
        int_ack = 1;
        tick();
        int_ack = 0; reti = 1;
        tick();
        reti = 0;
    endtask

    task automatic test_hold_and_ack_rise();
        int reqs;
        reqs = 0;
        irq = 4'b0001;
        tick();
        tick();
        n_cmp++; if (int_req !== 1'b1 || int_vector !== 10'h3F0) begin n_err++; $display("FAIL hold_req got req=%b vec=%h want req=1 vec=3f0", int_req, int_vector); end
        int_ack = 1;
        tick();
        int_ack = 0;
        tick();
        tick();
        n_cmp++; if (pending !== 4'b0000) begin n_err++; $display("FAIL hold_pend got %b want 0000", pending); end
        irq = 4'b0; reti = 1;
        tick();
        reti = 0;
        for (int i = 0; i < 4; i++) begin
            if (int_req === 1'b1) reqs++;
            tick();
        end
        n_cmp++; if (reqs !== 0) begin n_err++; $display("FAIL hold_once got %0d extra requests want 0", reqs); end
        irq = 4'b0001;
        tick();
        irq = 4'b0;
        tick();
        int_ack = 1; irq = 4'b0001;
        tick();
        int_ack = 0; irq = 4'b0;
        n_cmp++; if (pending !== 4'b0001) begin n_err++; $display("FAIL ack_rise_pend got %b want 0001", pending); end
        n_cmp++; if (in_service !== 1'b1) begin n_err++; $display("FAIL ack_rise_insvc got %b want 1", in_service); end
        reti = 1;
        tick();
        reti = 0;
        tick();
        n_cmp++; if (int_req !== 1'b1 || int_vector !== 10'h3F0) begin n_err++; $display("FAIL ack_rise_again got req=%b vec=%h want req=1 vec=3f0", int_req, int_vector); end
        int_ack = 1;
        tick();
        int_ack = 0; reti = 1;
        tick();
        reti = 0;
    endtask

    task automatic test_reset_in_service();
        irq = 4'b0100;
        tick();
        irq = 4'b1000;
        tick();
        int_ack = 1; irq = 4'b0;
        tick();
        int_ack = 0;
        n_cmp++; if (in_service !== 1'b1) begin n_err++; $display("FAIL rst_svc_pre got %b want 1", in_service); end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if (in_service !== 1'b0 || int_req !== 1'b0) begin n_err++; $display("FAIL rst_svc_out got insvc=%b req=%b want 0 0", in_service, int_req); end
        n_cmp++; if (pending !== 4'b0 || ie !== 1'b0 || int_vector !== 10'h3F0) begin n_err++; $display("FAIL rst_svc_regs got pend=%b ie=%b vec=%h want 0000 0 3f0", pending, ie, int_vector); end
        tick();
        reset = 1'b0;
        tick();
    endtask

`ifdef INTC_NESTING_EN
    task automatic test_nesting();
        do_reset();
        mask_we = 1; mask_din = 4'b1111; ei = 1;
        tick();
        idle_inputs(); irq = 4'b0100;
        tick();
        irq = 4'b0;
        tick();
        int_ack = 1;
        tick();
        int_ack = 0; ei = 1;
        tick();
        ei = 0; irq = 4'b0001;
        tick();
        irq = 4'b0;
        tick();
        n_cmp++; if (int_req !== 1'b1 || int_vector !== 10'h3F0) begin n_err++; $display("FAIL nest_preempt got req=%b vec=%h want req=1 vec=3f0", int_req, int_vector); end
        int_ack = 1;
        tick();
        int_ack = 0; reti = 1;
        tick();
        n_cmp++; if (in_service !== 1'b1 || ie !== 1'b0) begin n_err++; $display("FAIL nest_inner_ret got insvc=%b ie=%b want 1 0", in_service, ie); end
        tick();
        reti = 0;
        n_cmp++; if (in_service !== 1'b0 || ie !== 1'b1) begin n_err++; $display("FAIL nest_outer_ret got insvc=%b ie=%b want 0 1", in_service, ie); end
    endtask
`else
    task automatic test_random();
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            irq      = 4'($urandom_range(0, 15)) & ((c % 64 < 32) ? 4'b1111 : 4'b0101);
            mask_we  = ($urandom_range(0, 9) == 0);
            mask_din = 4'($urandom_range(0, 15));
            ei       = ($urandom_range(0, 3) == 0);
            di       = ($urandom_range(0, 9) == 0);
            reti     = ($urandom_range(0, 3) == 0);
            int_ack  = ($urandom_range(0, 1) == 0);
            tick();
            model_clock();
            n_cmp++; if (int_req !== (m_phase == 1)) begin n_err++; $display("FAIL rnd_req cyc %0d got %b want %b", c, int_req, (m_phase == 1)); end
            n_cmp++; if (in_service !== (m_phase == 2)) begin n_err++; $display("FAIL rnd_insvc cyc %0d got %b want %b", c, in_service, (m_phase == 2)); end
            n_cmp++; if (pending !== m_pend) begin n_err++; $display("FAIL rnd_pend cyc %0d got %b want %b", c, pending, m_pend); end
            n_cmp++; if (ie !== m_ie) begin n_err++; $display("FAIL rnd_ie cyc %0d got %b want %b", c, ie, m_ie); end
            if (m_phase == 1) begin
                n_cmp++; if (int_vector !== 10'h3F0 + 10'(m_src)) begin n_err++; $display("FAIL rnd_vec cyc %0d got %h want %h", c, int_vector, 10'h3F0 + 10'(m_src)); end
            end
        end
        idle_inputs();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_priority();
        test_mask();
        test_di_drop();
        test_hold_and_ack_rise();
        test_reset_in_service();
`ifdef INTC_NESTING_EN
        test_nesting();
`else
        test_random();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
